fifo_write_arbiter: RTL and testbench

Shares the single write port of the VGA pixel FIFO between two pixel producers: requester 0 is the line engine, requester 1 is an overlay/sprite engine. It sits between the producers and `vga`, takes `fifo_full` from `vga`, and drives `fifo_write`/`fifo_data`. Arbitration is round-robin with a bounded burst length and is re-synchronised on every `vtrigger` frame pulse. Per-frame accepted-word counts are exported as status.

---
 rtl/vga16_pkg.sv | 34 +++
 rtl/sat_counter.sv | 39 +++
 rtl/fifo_write_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga16_pkg.sv
// Shared types and helpers for the VGA pixel path: arbiter states,
// default pixel width and requester count.
package vga16_pkg;

    localparam int PIX_W   = 16;
    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] owner_onehot(input arb_state_t s);
        logic [NUM_REQ-1:0] oh;
        case (s)
            OWN0:    oh = 2'b01;
            OWN1:    oh = 2'b10;
            default: oh = 2'b00;
        endcase
        return oh;
    endfunction

    function automatic arb_state_t own_state(input logic idx);
        arb_state_t s;
        if (idx) begin
            s = OWN1;
        end else begin
            s = OWN0;
        end
        return s;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; sticks at all-ones
// instead of wrapping. Clear takes priority over increment.
module sat_counter #(
    parameter int W = 20
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // next count: clear, saturating increment, or hold
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the VGA pixel FIFO write port
// between the line engine (req 0) and the overlay engine (req 1).
module fifo_write_arbiter
    import vga16_pkg::*;
#(
    parameter int DATA_W = PIX_W,
    parameter int BURST  = 16,
    parameter int CNT_W  = 20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      trigger,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_write,
    output logic [DATA_W-1:0]         fifo_data,
    output logic [CNT_W-1:0]          frame_words0,
    output logic [CNT_W-1:0]          frame_words1,
    output logic [NUM_REQ-1:0]        owner
);

    localparam int                 BCNT_W     = $clog2(BURST + 1);
    localparam logic [BCNT_W-1:0]  BURST_LAST = BCNT_W'(BURST);

    arb_state_t           state_q, state_d;
    logic                 rr_q, rr_d;
    logic [BCNT_W-1:0]    bcnt_q, bcnt_d;
    logic [CNT_W-1:0]     fw0_q, fw0_d;
    logic [CNT_W-1:0]     fw1_q, fw1_d;
    logic [CNT_W-1:0]     run0_s, run1_s;
    logic [NUM_REQ-1:0]   accept_s;
    logic [BCNT_W-1:0]    bcnt_inc_s;
    logic                 cur_s;
    logic                 oth_s;
    logic                 release_s;

    // Frame snapshot must include a word accepted in the trigger cycle itself.
    function automatic logic [CNT_W-1:0] sat_step(input logic [CNT_W-1:0] c, input logic inc);
        logic [CNT_W-1:0] r;
        if (inc && (c != {CNT_W{1'b1}})) begin
            r = c + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            r = c;
        end
        return r;
    endfunction

    // grant decode and write-port data path
    always_comb begin
        owner = owner_onehot(state_q);
        if (fifo_full) begin
            req_ready = 2'b00;
        end else begin
            req_ready = owner;
        end
        accept_s   = req_write & req_ready;
        fifo_write = |accept_s;
        case (state_q)
            OWN0:    fifo_data = req_data[DATA_W-1:0];
            OWN1:    fifo_data = req_data[2*DATA_W-1:DATA_W];
            default: fifo_data = '0;
        endcase
    end

    // arbitration next-state, round-robin pointer and burst counter
    always_comb begin
        state_d    = state_q;
        rr_d       = rr_q;
        bcnt_d     = bcnt_q;
        cur_s      = (state_q == OWN1);
        oth_s      = ~cur_s;
        bcnt_inc_s = bcnt_q + {{(BCNT_W-1){1'b0}}, 1'b1};
        release_s  = (state_q != IDLE) &&
                     ((fifo_write && (bcnt_inc_s == BURST_LAST)) || !req_write[cur_s]);
        if (trigger) begin
            if (req_write[0]) begin
                state_d = OWN0;
            end else begin
                state_d = IDLE;
            end
            rr_d   = 1'b0;
            bcnt_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    case (req_write)
                        2'b01:   state_d = OWN0;
                        2'b10:   state_d = OWN1;
                        2'b11:   state_d = own_state(rr_q);
                        default: state_d = IDLE;
                    endcase
                end
                OWN0, OWN1: begin
                    if (release_s) begin
                        rr_d   = oth_s;
                        bcnt_d = '0;
                        if (req_write[oth_s]) begin
                            state_d = own_state(oth_s);
                        end else if (req_write[cur_s]) begin
                            state_d = state_q;
                        end else begin
                            state_d = IDLE;
                        end
                    end else if (fifo_write) begin
                        bcnt_d = bcnt_inc_s;
                    end else begin
                        bcnt_d = bcnt_q;
                    end
                end
                default: begin
                    state_d = IDLE;
                    bcnt_d  = '0;
                end
            endcase
        end
    end

    // previous-frame word counts, captured on the frame pulse
    always_comb begin
        fw0_d = fw0_q;
        fw1_d = fw1_q;
        if (trigger) begin
            fw0_d = sat_step(run0_s, accept_s[0]);
            fw1_d = sat_step(run1_s, accept_s[1]);
        end else begin
            fw0_d = fw0_q;
            fw1_d = fw1_q;
        end
    end

    // state registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            bcnt_q  <= '0;
            fw0_q   <= '0;
            fw1_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            bcnt_q  <= bcnt_d;
            fw0_q   <= fw0_d;
            fw1_q   <= fw1_d;
        end
    end

    sat_counter #(.W(CNT_W)) u_run0 (
        .clk   (clk),
        .rst_n (reset),
        .clear (trigger),
        .inc   (accept_s[0]),
        .count (run0_s)
    );

    sat_counter #(.W(CNT_W)) u_run1 (
        .clk   (clk),
        .rst_n (reset),
        .clear (trigger),
        .inc   (accept_s[1]),
        .count (run1_s)
    );

    assign frame_words0 = fw0_q;
    assign frame_words1 = fw1_q;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: expected FIFO words are queued as
// stimulus is planned and popped as the DUT writes; a CNT_W=4 twin checks saturation.
module tb_fifo_write_arbiter;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  own;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        trigger = 1'b0;
    logic [1:0]  req_write = 2'b00;
    logic [31:0] req_data = 32'h0;
    logic        fifo_full = 1'b0;
    logic [1:0]  req_ready;
    logic        fifo_write;
    logic [15:0] fifo_data;
    logic [19:0] frame_words0, frame_words1;
    logic [1:0]  owner;

    logic [1:0]  s4_req_ready;
    logic        s4_fifo_write;
    logic [15:0] s4_fifo_data;
    logic [3:0]  s4_fw0, s4_fw1;
    logic [1:0]  s4_owner;

    exp_t sb[$];
    int   base[2];
    int   seq[2];
    int   rem[2];
    int   cyc = 0;
    int   first_wr = -1;
    int   last_wr = -1;
    int   n_checks = 0;
    int   n_fail = 0;
    logic nxt_trigger = 1'b0;
    logic nxt_full = 1'b0;
    int   p;

    fifo_write_arbiter #(.DATA_W(16), .BURST(16), .CNT_W(20)) dut (
        .clk(clk), .reset(reset), .trigger(trigger), .req_write(req_write),
        .req_data(req_data), .req_ready(req_ready), .fifo_full(fifo_full),
        .fifo_write(fifo_write), .fifo_data(fifo_data),
        .frame_words0(frame_words0), .frame_words1(frame_words1), .owner(owner)
    );

    fifo_write_arbiter #(.DATA_W(16), .BURST(16), .CNT_W(4)) dut_sat (
        .clk(clk), .reset(reset), .trigger(trigger), .req_write(req_write),
        .req_data(req_data), .req_ready(s4_req_ready), .fifo_full(fifo_full),
        .fifo_write(s4_fifo_write), .fifo_data(s4_fifo_data),
        .frame_words0(s4_fw0), .frame_words1(s4_fw1), .owner(s4_owner)
    );

    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic push_words(input int r, input int first, input int n);
        for (int k = 0; k < n; k++) begin
            sb.push_back('{data: 16'(base[r] + first + k), own: (r == 1) ? 2'b10 : 2'b01});
        end
    endtask

    task automatic load(input int r, input int b, input int n);
        base[r] = b;
        seq[r]  = 0;
        rem[r]  = n;
    endtask

    // One clock: drive at negedge, sample 1ns later, account handshakes.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        trigger   = nxt_trigger;
        nxt_trigger = 1'b0;
        fifo_full = nxt_full;
        for (int i = 0; i < 2; i++) begin
            req_write[i]         = (rem[i] != 0);
            req_data[i*16 +: 16] = 16'(base[i] + seq[i]);
        end
        #1;
        if (fifo_write) begin
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
            chk_eq("no_write_when_full", {31'h0, fifo_full}, 32'h0);
            chk_eq("sb_has_entry", {31'h0, sb.size() != 0}, 32'h1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk_eq("fifo_data", {16'h0, fifo_data}, {16'h0, e.data});
                chk_eq("owner_on_write", {30'h0, owner}, {30'h0, e.own});
            end
        end
        for (int i = 0; i < 2; i++) begin
            if (req_write[i] && req_ready[i]) begin
                seq[i]++;
                rem[i]--;
            end
        end
    endtask

    task automatic run_done(input string tag);
        int n = 0;
        while ((sb.size() != 0 || rem[0] != 0 || rem[1] != 0) && n < 2000) begin
            step();
            n++;
        end
        chk_eq(tag, {31'h0, n < 2000}, 32'h1);
    endtask

    task automatic run_seq1(input int target, input string tag);
        int n = 0;
        while (seq[1] < target && n < 2000) begin
            step();
            n++;
        end
        chk_eq(tag, {31'h0, n < 2000}, 32'h1);
    endtask

    task automatic frame_check(input string tag, input int e0, input int e1);
        nxt_trigger = 1'b1;
        step();
        step();
        chk_eq({tag, "_fw0"}, {12'h0, frame_words0}, 32'(e0));
        chk_eq({tag, "_fw1"}, {12'h0, frame_words1}, 32'(e1));
        chk_eq({tag, "_sat_fw0"}, {28'h0, s4_fw0}, 32'((e0 > 15) ? 15 : e0));
        chk_eq({tag, "_sat_fw1"}, {28'h0, s4_fw1}, 32'((e1 > 15) ? 15 : e1));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk_eq({tag, "_owner"}, {30'h0, owner}, 32'h0);
        chk_eq({tag, "_ready"}, {30'h0, req_ready}, 32'h0);
        chk_eq({tag, "_write"}, {31'h0, fifo_write}, 32'h0);
        chk_eq({tag, "_data"}, {16'h0, fifo_data}, 32'h0);
        chk_eq({tag, "_fw0"}, {12'h0, frame_words0}, 32'h0);
        chk_eq({tag, "_fw1"}, {12'h0, frame_words1}, 32'h0);
        chk_eq({tag, "_sat_fw0"}, {28'h0, s4_fw0}, 32'h0);
    endtask

    initial begin
        load(0, 0, 0);
        load(1, 0, 0);
        #1 reset = 1'b0;
        #1 chk_reset_outputs("por");
        repeat (3) @(negedge clk);
        reset = 1'b1;

        // single requester, 40 words, bursts invisible but gap-free
        load(0, 32'h1000, 40);
        push_words(0, 0, 40);
        p = cyc + 1;
        first_wr = -1;
        run_done("t1_done");
        chk_eq("t1_latency", 32'(first_wr), 32'(p + 1));
        chk_eq("t1_last", 32'(last_wr), 32'(p + 40));
        frame_check("t1", 40, 0);

        // contention with a 5-cycle stall inside the first req1 burst
        load(0, 32'h2000, 48);
        load(1, 32'hA000, 48);
        for (int b = 0; b < 3; b++) begin
            push_words(0, b * 16, 16);
            push_words(1, b * 16, 16);
        end
        p = cyc + 1;
        first_wr = -1;
        run_seq1(5, "t3_reach");
        nxt_full = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk_eq("t3_ready", {30'h0, req_ready}, 32'h0);
            chk_eq("t3_write", {31'h0, fifo_write}, 32'h0);
            chk_eq("t3_owner", {30'h0, owner}, 32'h2);
        end
        nxt_full = 1'b0;
        run_done("t2_done");
        chk_eq("t2_first", 32'(first_wr), 32'(p + 1));
        chk_eq("t2_last", 32'(last_wr), 32'(p + 101));
        frame_check("t2", 48, 48);

        // trigger after 7 req1 words; the 8th is accepted in the trigger cycle
        load(0, 32'h3000, 32);
        load(1, 32'hC000, 24);
        push_words(0, 0, 16);
        push_words(1, 0, 8);
        push_words(0, 16, 16);
        push_words(1, 8, 16);
        run_seq1(7, "t4_reach");
        nxt_trigger = 1'b1;
        step();
        step();
        chk_eq("t4_owner_after", {30'h0, owner}, 32'h1);
        chk_eq("t4_fw0", {12'h0, frame_words0}, 32'd16);
        chk_eq("t4_fw1", {12'h0, frame_words1}, 32'd8);
        chk_eq("t4_sat_fw0", {28'h0, s4_fw0}, 32'd15);
        chk_eq("t4_sat_fw1", {28'h0, s4_fw1}, 32'd8);
        run_done("t4_done");
        frame_check("t4_next", 16, 16);

        // saturation of the 4-bit twin
        load(0, 32'h4000, 20);
        push_words(0, 0, 20);
        run_done("t5_done");
        frame_check("t5", 20, 0);

        // async reset during an req1 burst (rr=1 at that point)
        load(0, 32'h5000, 16);
        load(1, 32'hD000, 10);
        push_words(0, 0, 16);
        push_words(1, 0, 3);
        run_seq1(3, "t6_reach");
        @(posedge clk);
        #2 reset = 1'b0;
        #1 chk_reset_outputs("t6_async");
        chk_eq("t6_sb_drained", 32'(sb.size()), 32'h0);
        load(0, 0, 0);
        load(1, 0, 0);
        req_write = 2'b00;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        load(0, 32'h6000, 20);
        load(1, 32'hE000, 20);
        push_words(0, 0, 16);
        push_words(1, 0, 16);
        push_words(0, 16, 4);
        push_words(1, 16, 4);
        p = cyc + 1;
        first_wr = -1;
        run_done("t6_done");
        chk_eq("t6_latency", 32'(first_wr), 32'(p + 1));
        repeat (2) step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
